// File: rtl/lift_call_dispatcher.sv
// Purpose : latches hall calls, picks the pending floor nearest the car, issues it to the lift and retires/retries it.
// Latency : a press reaches pending_o one edge after it is sampled; butt_up_down_o pulses two edges later.
// Backpress: calls are issued one at a time; new presses only accumulate in pending_o while a call is outstanding.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset; drops every pending call
//   hall_call_i     bit f = press on floor f (bit 0 and bits above NUM_FLOORS ignored)
//   elev_f_i        current car floor (from lift elev_f_o)
//   busy_i          lift busy flag (from lift busy_o)
//   butt_up_down_o  one-cycle call pulse to the lift
//   pass_f_o        floor of the call being issued, held until the next selection
//   pending_o       latched hall calls (call lamps)
//   dispatch_busy_o high whenever the dispatcher is not idle
//   err_o           one-cycle pulse when the lift fails to acknowledge a call
module lift_call_dispatcher #(
    parameter int NUM_FLOORS  = 7,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hall_call_i,
    input  logic [2:0] elev_f_i,
    input  logic       busy_i,
    output logic       butt_up_down_o,
    output logic [2:0] pass_f_o,
    output logic [7:0] pending_o,
    output logic       dispatch_busy_o,
    output logic       err_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    // Floors that may ever be latched: 1..NUM_FLOORS.
    function automatic logic [7:0] make_floor_mask();
        logic [7:0] m;
        m = 8'd0;
        for (int i = 1; i < 8; i++) begin
            if (i <= NUM_FLOORS) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [7:0] FLOOR_MASK = make_floor_mask();

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    state_t           state;
    logic [7:0]       pending;
    logic [2:0]       target;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] ack_cnt_inc;

    logic [2:0]       near_f;
    logic             retire;
    logic [7:0]       retire_mask;

    // ------------------------------------------------------------------
    // Nearest pending floor. Floors are scanned upwards and only a
    // strictly smaller distance replaces the current best, so a tie
    // keeps the lower floor.
    // ------------------------------------------------------------------
    always_comb begin
        logic [2:0] best_d;
        logic [2:0] d;
        logic [2:0] fi;
        logic       found;
        near_f = 3'd1;
        best_d = 3'd7;
        found  = 1'b0;
        d      = 3'd0;
        fi     = 3'd0;
        for (int i = 1; i < 8; i++) begin
            fi = 3'(i);
            d  = (fi >= elev_f_i) ? (fi - elev_f_i) : (elev_f_i - fi);
            if (pending[i] && (!found || (d < best_d))) begin
                found  = 1'b1;
                near_f = fi;
                best_d = d;
            end
        end
    end

    // A call is retired only when the lift went idle at the requested floor.
    assign retire      = (state == ST_WAIT_DONE) && !busy_i && (elev_f_i == target);
    assign retire_mask = retire ? (8'd1 << target) : 8'd0;

    // Saturating increment so the counter can never wrap past the limit.
    assign ack_cnt_inc = (ack_cnt == CNT_MAX) ? ack_cnt : ack_cnt + 1'b1;

    // ------------------------------------------------------------------
    // Pending calls: set by presses, cleared by retirement. The clear is
    // applied after the set, so a press landing on the retiring floor in
    // the same cycle is discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 8'd0;
        end else begin
            pending <= (pending | (hall_call_i & FLOOR_MASK)) & ~retire_mask;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM with registered outputs. dispatch_busy_o is loaded with
    // "next state is not IDLE" so it tracks the state register exactly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            target          <= 3'd1;
            ack_cnt         <= '0;
            butt_up_down_o  <= 1'b0;
            dispatch_busy_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            butt_up_down_o <= 1'b0;
            err_o          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending != 8'd0) begin
                        state           <= ST_SELECT;
                        dispatch_busy_o <= 1'b1;
                    end
                end

                ST_SELECT: begin
                    if (pending == 8'd0) begin
                        state           <= ST_IDLE;
                        dispatch_busy_o <= 1'b0;
                    end else begin
                        target         <= near_f;
                        butt_up_down_o <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    if (busy_i) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt_inc;
                        // Unacknowledged call stays pending; IDLE retries it.
                        if (ack_cnt_inc == CNT_MAX) begin
                            err_o           <= 1'b1;
                            state           <= ST_IDLE;
                            dispatch_busy_o <= 1'b0;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    // Leaving on a floor mismatch keeps the bit set, so the
                    // call is dispatched again from the new car position.
                    if (!busy_i) begin
                        state           <= ST_IDLE;
                        dispatch_busy_o <= 1'b0;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    dispatch_busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign pass_f_o  = target;
    assign pending_o = pending;

endmodule

// File: tb/tb_lift_call_dispatcher.sv
module tb_lift_call_dispatcher;

    localparam int NF = 7;
    localparam int TO = 16;

    localparam int K_OK      = 0;
    localparam int K_WRONG   = 1;
    localparam int K_TIMEOUT = 2;

    typedef struct {
        int floor;
        int kind;
        int dest;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] hall_call = 8'd0;
    logic [2:0] elev = 3'd1;
    logic       busy = 1'b0;
    logic       butt;
    logic [2:0] pass_f;
    logic [7:0] pending;
    logic       dbusy;
    logic       err;

    lift_call_dispatcher #(.NUM_FLOORS(NF), .ACK_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .hall_call_i     (hall_call),
        .elev_f_i        (elev),
        .busy_i          (busy),
        .butt_up_down_o  (butt),
        .pass_f_o        (pass_f),
        .pending_o       (pending),
        .dispatch_busy_o (dbusy),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected issues, in order, consumed by the monitor.
    step_t exp_q[$];

    // ------------------------------------------------------------------
    // Monitor: every pulse must match the next expected floor; every err
    // must follow a call the lift was told to ignore, 17 samples after it.
    // ------------------------------------------------------------------
    int    cyc        = 0;
    int    issue_cyc  = 0;
    int    issue_kind = -1;
    bit    prev_butt  = 1'b0;
    step_t mon_s;

    always @(negedge clk) begin
        if (rst) begin
            prev_butt = 1'b0;
        end else begin
            cyc++;
            if (butt === 1'b1) begin
                check("pulse_width", 32'(prev_butt), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse pass_f=%0d expected=no pulse", pass_f);
                end else begin
                    mon_s = exp_q.pop_front();
                    check("pass_f", 32'(pass_f), mon_s.floor);
                    issue_cyc  = cyc;
                    issue_kind = mon_s.kind;
                end
            end
            if (err === 1'b1) begin
                check("err_cause", issue_kind, K_TIMEOUT);
                check("err_delay", cyc - issue_cyc, TO + 1);
            end
            prev_butt = (butt === 1'b1);
        end
    end

    // Reference selection: grow a window around the car; lower side first.
    function automatic int nearest(input logic [7:0] p, input int e);
        for (int d = 0; d < 8; d++) begin
            if (e - d >= 1 && p[e-d]) return e - d;
            if (e + d <= NF && p[e+d]) return e + d;
        end
        return 0;
    endfunction

    task automatic recover();
        rst       = 1'b1;
        busy      = 1'b0;
        hall_call = 8'd0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One episode: presses from an idle, empty dispatcher; the model plans
    // every issue and lift reaction until all calls are served.
    task automatic run_episode(input logic [7:0] press, input int e0, input int forced,
                               input int wdest, input bit edge_press);
        logic [7:0] p;
        int         e;
        int         n;
        int         r;
        step_t      s;
        step_t      plan[$];

        p = press & 8'hFE;
        e = e0;
        while (p != 8'd0) begin
            s.floor = nearest(p, e);
            if (plan.size() == 0 && forced >= 0) begin
                s.kind = forced;
            end else if (plan.size() >= 12) begin
                s.kind = K_OK;
            end else begin
                r = $urandom_range(0, 9);
                s.kind = (r < 6) ? K_OK : ((r < 8) ? K_WRONG : K_TIMEOUT);
            end
            s.dest = s.floor;
            if (s.kind == K_WRONG) begin
                if (plan.size() == 0 && forced >= 0) begin
                    s.dest = wdest;
                end else begin
                    do s.dest = $urandom_range(1, NF); while (s.dest == s.floor);
                end
            end
            if (s.kind == K_OK)       p[s.floor] = 1'b0;
            if (s.kind != K_TIMEOUT)  e = s.dest;
            plan.push_back(s);
            exp_q.push_back(s);
        end

        elev      = 3'(e0);
        hall_call = press;
        @(negedge clk);
        check("pending_after_press", 32'(pending), 32'(press & 8'hFE));
        // Keep pressing one more cycle: an already pending floor must not
        // cause an additional dispatch.
        @(negedge clk);
        hall_call = 8'd0;

        foreach (plan[i]) begin
            s = plan[i];
            n = 0;
            while (butt !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (butt !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL pulse_wait no pulse after %0d cycles, expected floor %0d", n, s.floor);
                recover();
                return;
            end
            if (i == 0) check("first_pulse_latency", n, 1);

            if (s.kind == K_TIMEOUT) begin
                n = 0;
                while (err !== 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                if (err !== 1'b1) begin
                    checks++;
                    failures++;
                    $display("FAIL err_wait no err after %0d cycles, expected err", n);
                    recover();
                    return;
                end
                check("timeout_keeps_bit", 32'(pending[s.floor]), 1);
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                busy = 1'b0;
                elev = 3'(s.dest);
                if (edge_press && s.kind == K_OK) hall_call = 8'd1 << s.floor;
                @(negedge clk);
                hall_call = 8'd0;
                check(s.kind == K_OK ? "retire_clears_bit" : "wrong_floor_keeps_bit",
                      32'(pending[s.floor]), (s.kind == K_OK) ? 0 : 1);
            end
        end

        repeat (4) @(negedge clk);
        check("pending_end", 32'(pending), 0);
        check("idle_end", 32'(dbusy), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    step_t rs;

    initial begin
        int n;
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_pending", 32'(pending), 0);
        check("rst_butt", 32'(butt), 0);
        check("rst_pass_f", 32'(pass_f), 1);
        check("rst_dbusy", 32'(dbusy), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset in WAIT_DONE with three calls pending.
        elev     = 3'd4;
        rs.floor = 4;
        rs.kind  = K_OK;
        rs.dest  = 4;
        exp_q.push_back(rs);
        hall_call = 8'b0101_0100;
        @(negedge clk);
        hall_call = 8'd0;
        n = 0;
        while (butt !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("midrst_pulse_seen", 32'(butt), 1);
        @(negedge clk);
        busy = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_pending_before", 32'(pending), 32'h54);
        check("midrst_dbusy_before", 32'(dbusy), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pending", 32'(pending), 0);
        check("midrst_dbusy", 32'(dbusy), 0);
        check("midrst_pass_f", 32'(pass_f), 1);
        check("midrst_butt", 32'(butt), 0);
        check("midrst_err", 32'(err), 0);
        @(negedge clk);
        rst  = 1'b0;
        busy = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_stays_empty", 32'(pending), 0);

        // Directed episodes.
        run_episode(8'b0010_0000, 1, K_OK, 0, 1'b0);      // single call
        run_episode(8'b0100_0100, 4, K_OK, 0, 1'b0);      // tie -> floor 2 first
        run_episode(8'b1000_1000, 6, K_OK, 0, 1'b0);      // floor 7 first
        run_episode(8'b0000_1000, 1, K_TIMEOUT, 0, 1'b0); // ack timeout then retry
        run_episode(8'b0010_0000, 1, K_WRONG, 3, 1'b0);   // incomplete service
        run_episode(8'b0010_0000, 1, K_OK, 0, 1'b1);      // press during retirement
        run_episode(8'b0000_0001, 2, -1, 0, 1'b0);        // floor 0 ignored

        // Randomized episodes.
        for (int k = 0; k < 25; k++) begin
            run_episode(8'($urandom_range(1, 255)), $urandom_range(1, NF), -1, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        failures++;
        $display("FAIL watchdog simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lift_call_dispatcher.md
# lift_call_dispatcher

The hall-call dispatcher sits on the initiator side of the lift controller's call interface. It latches hall-call button presses from every floor and selects the pending call nearest the car. It issues one call at a time to the lift as a `butt_up_down` pulse with `pass_f`, then tracks the lift's busy/floor feedback to retire served calls, retry unserved ones and flag unresponsive lifts.

## Interface
Parameters:
- `NUM_FLOORS`, default 7: highest valid floor code. Floors are 1..`NUM_FLOORS` in 3-bit code; code 0 is unused.
- `ACK_TIMEOUT`, default 16: maximum number of cycles spent waiting for `busy_i` to rise after a call is issued.

Ports:
- `clk`  in  1  — the single clock; all logic runs on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `hall_call_i`  in  8  — bit f is a hall-call press on floor f. Bit 0 and bits above `NUM_FLOORS` are ignored. Level or pulse inputs are both accepted.
- `elev_f_i`  in  3  — current lift floor, taken from the lift's `elev_f_o`.
- `busy_i`  in  1  — lift busy flag, taken from the lift's `busy_o`.
- `butt_up_down_o`  out  1  — one-cycle call pulse to the lift.
- `pass_f_o`  out  3  — floor of the call being issued; held stable from ISSUE through the end of WAIT_DONE.
- `pending_o`  out  8  — latched hall calls, used to drive the call lamps.
- `dispatch_busy_o`  out  1  — high whenever the state is not IDLE.
- `err_o`  out  1  — one-cycle pulse on acknowledge timeout.

## Operation
- Pending register:
  - Set: `pending[f]` is set at any edge where `hall_call_i[f]` is 1 and 1 ≤ f ≤ `NUM_FLOORS`.
  - Clear: `pending[f]` is cleared only on retirement (WAIT_DONE exit with `elev_f_i` equal to the target).
  - If a set and a clear hit the same bit on the same edge, the clear wins.
  - A press on a floor that is already pending has no effect.
- FSM states, all registered: IDLE, SELECT, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: when `pending` is nonzero, go to SELECT.
  - SELECT:
    - Sample `elev_f_i` and register `target` as the pending floor f that minimises |f − `elev_f_i`|.
    - Ties go to the lower floor.
    - A pending bit at `elev_f_i` has distance 0 and is chosen.
    - If `pending` became zero in the meantime, return to IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: drive `butt_up_down_o`=1 and `pass_f_o`=`target`; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK:
    - If `busy_i`=1, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches `ACK_TIMEOUT`, pulse `err_o`, leave the call pending and go to IDLE, which causes a retry.
  - WAIT_DONE:
    - Stay while `busy_i`=1.
    - When `busy_i`=0 and `elev_f_i`=`target`: clear `pending[target]` and go to IDLE.
    - When `busy_i`=0 and `elev_f_i`≠`target`: leave the bit set and go to IDLE, which re-dispatches the call.
- Arithmetic:
  - Distance is a 3-bit unsigned absolute difference.
  - The counter is $clog2(`ACK_TIMEOUT`+1) bits wide and does not wrap; it saturates at the compare value.
- Outputs:
  - `butt_up_down_o`, `err_o` and `dispatch_busy_o` are registered.
  - `butt_up_down_o` is high only in the ISSUE cycle.
  - `pass_f_o` retains its last value in IDLE.
- Reset mid-operation: the FSM returns immediately to IDLE and all pending calls are dropped.

## Timing
- Reset values: state IDLE, `pending_o`=0, `pass_f_o`=3'b001, `butt_up_down_o`=0, `dispatch_busy_o`=0, `err_o`=0, counter=0.
- Press latency:
  - A press sampled at edge E0 is visible on `pending_o` after E0.
  - The FSM reaches SELECT at E1 and ISSUE at E2.
  - `butt_up_down_o` is high for exactly the cycle after E2, with `pass_f_o` valid in the same cycle.
- Acknowledge window: `busy_i` is sampled from the first WAIT_ACK cycle. If `busy_i` stays 0, `err_o` pulses `ACK_TIMEOUT` cycles after entry.
- Throughput: the minimum gap between consecutive `butt_up_down_o` pulses is 5 cycles (ISSUE, WAIT_ACK, WAIT_DONE, IDLE, SELECT).
- Retirement: the `pending_o` bit falls on the edge at which WAIT_DONE samples `busy_i`=0 with a matching floor.

## Test plan
- Reset: assert `rst` asynchronously while in WAIT_DONE with 3 calls pending → outputs take their reset values before the next edge, and `dispatch_busy_o`=0.
- Single call: `elev_f_i`=1, press floor 5 → `pending_o`=8'b0010_0000, and after 2 cycles a 1-cycle pulse with `pass_f_o`=5. Model raises `busy_i` 1 cycle later and drops it after 10 cycles with `elev_f_i`=5 → bit 5 clears and the FSM returns to IDLE.
- Nearest with tie: pending floors 2 and 6, `elev_f_i`=4 → floor 2 issued first, then floor 6. Pending floors 3 and 7 with `elev_f_i`=6 → floor 7 issued first.
- Timeout: call floor 3, `busy_i` held 0 → `err_o` pulses exactly 16 cycles after WAIT_ACK entry, bit 3 stays set, and a new pulse with `pass_f_o`=3 follows.
- Incomplete service: target 5, `busy_i` falls with `elev_f_i`=3 → `pending_o[5]` stays 1 and floor 5 is re-issued.
- Edge inputs: press floor 5 on the same edge as floor 5 retirement → bit 5 ends at 0. Press `hall_call_i[0]` → no effect. Repeated press of an already pending floor → no extra dispatch.
